// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state encoding and
// the requester index width helper.
package mult_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } arb_state_t;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping at NUM_REQ, returned as one-hot grant plus binary index.
module rr_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   always_comb begin
      int k;
      k         = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      // Walk from the farthest offset down so the nearest one to rr_ptr wins last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = (int'(rr_ptr) + i) % NUM_REQ;
         if (1'(req >> k)) begin
            grant     = NUM_REQ'(1) << k;
            grant_idx = IDX_W'(k);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one shift_add_multiplier between NUM_REQ requesters, one op in flight.
// Optional MULT_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier and return 0.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_tvalid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_tdata_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_tdata_b,
   output logic [NUM_REQ-1:0]         req_tready,
   output logic [NUM_REQ-1:0]         rsp_tvalid,
   output logic [WIDTH-1:0]           rsp_tdata,
   input  logic [NUM_REQ-1:0]         rsp_tready,
   output logic                       mul_tvalid_1,
   output logic [WIDTH-1:0]           mul_tdata_1,
   input  logic                       mul_tready_1,
   output logic                       mul_tvalid_2,
   output logic [WIDTH-1:0]           mul_tdata_2,
   input  logic                       mul_tready_2,
   input  logic                       mul_tvalid_r,
   input  logic [WIDTH-1:0]           mul_tdata_r,
   output logic                       mul_tready_r
);

   localparam int IDX_W = idx_w(NUM_REQ);

   arb_state_t              state;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        grant_idx;
   logic signed [WIDTH-1:0] op_a;
   logic signed [WIDTH-1:0] op_b;

   logic [NUM_REQ-1:0]      arb_grant;
   logic [IDX_W-1:0]        arb_idx;
   logic                    arb_any;
   logic [IDX_W-1:0]        next_ptr;
   logic signed [WIDTH-1:0] in_a;
   logic signed [WIDTH-1:0] in_b;
   logic                    zero_op;
   logic                    issue_done;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req       (req_tvalid),
      .rr_ptr    (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   assign req_tready = (reset_n && state == ST_IDLE && arb_any) ? arb_grant : '0;
   assign next_ptr   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;

   always_comb begin
      in_a = '0;
      in_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            in_a = req_tdata_a[i*WIDTH +: WIDTH];
            in_b = req_tdata_b[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MULT_ARB_ZERO_BYPASS_EN
   assign zero_op = (in_a == '0) || (in_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // An operand port is finished once its valid is low or is being accepted now.
   assign issue_done = (!mul_tvalid_1 || mul_tready_1) && (!mul_tvalid_2 || mul_tready_2);

   assign mul_tdata_1 = op_a;
   assign mul_tdata_2 = op_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         grant_idx    <= '0;
         op_a         <= '0;
         op_b         <= '0;
         mul_tvalid_1 <= 1'b0;
         mul_tvalid_2 <= 1'b0;
         mul_tready_r <= 1'b0;
         rsp_tvalid   <= '0;
         rsp_tdata    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  op_a      <= in_a;
                  op_b      <= in_b;
                  grant_idx <= arb_idx;
                  rr_ptr    <= next_ptr;
                  if (zero_op) begin
                     rsp_tdata  <= '0;
                     rsp_tvalid <= arb_grant;
                     state      <= ST_RESPOND;
                  end else begin
                     mul_tvalid_1 <= 1'b1;
                     mul_tvalid_2 <= 1'b1;
                     state        <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (mul_tready_1) mul_tvalid_1 <= 1'b0;
               if (mul_tready_2) mul_tvalid_2 <= 1'b0;
               if (issue_done) begin
                  mul_tready_r <= 1'b1;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mul_tvalid_r) begin
                  rsp_tdata    <= mul_tdata_r;
                  rsp_tvalid   <= NUM_REQ'(1) << grant_idx;
                  mul_tready_r <= 1'b0;
                  state        <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               if (rsp_tready[grant_idx]) begin
                  rsp_tvalid <= '0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier, queued requesters and a
// transaction-level reference (round-robin pointer, one op in flight, signed products).
module tb_mult_share_arbiter;

   localparam int WIDTH   = 16;
   localparam int NUM_REQ = 4;
`ifdef MULT_ARB_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       req_tvalid;
   logic [NUM_REQ*WIDTH-1:0] req_tdata_a;
   logic [NUM_REQ*WIDTH-1:0] req_tdata_b;
   logic [NUM_REQ-1:0]       req_tready;
   logic [NUM_REQ-1:0]       rsp_tvalid;
   logic [WIDTH-1:0]         rsp_tdata;
   logic [NUM_REQ-1:0]       rsp_tready;
   logic                     mul_tvalid_1, mul_tready_1;
   logic [WIDTH-1:0]         mul_tdata_1;
   logic                     mul_tvalid_2, mul_tready_2;
   logic [WIDTH-1:0]         mul_tdata_2;
   logic                     mul_tvalid_r, mul_tready_r;
   logic [WIDTH-1:0]         mul_tdata_r;

   always #5 clk = ~clk;

   mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_tvalid   (req_tvalid),
      .req_tdata_a  (req_tdata_a),
      .req_tdata_b  (req_tdata_b),
      .req_tready   (req_tready),
      .rsp_tvalid   (rsp_tvalid),
      .rsp_tdata    (rsp_tdata),
      .rsp_tready   (rsp_tready),
      .mul_tvalid_1 (mul_tvalid_1),
      .mul_tdata_1  (mul_tdata_1),
      .mul_tready_1 (mul_tready_1),
      .mul_tvalid_2 (mul_tvalid_2),
      .mul_tdata_2  (mul_tdata_2),
      .mul_tready_2 (mul_tready_2),
      .mul_tvalid_r (mul_tvalid_r),
      .mul_tdata_r  (mul_tdata_r),
      .mul_tready_r (mul_tready_r)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] prod16(input logic [15:0] a, input logic [15:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[15:0];
   endfunction

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   // Stimulus and model state
   logic [31:0]        rq[NUM_REQ][$];
   logic [NUM_REQ-1:0] gate, rsp_rdy;
   bit                 rand_gate, rand_rsp, stall_after_1;
   int                 mul_lat;
   bit                 m_have_a, m_have_b, m_res_vld;
   logic [15:0]        m_a, m_b, m_res, inf_p, last_rsp;
   int                 m_cnt, stall_cnt;
   int                 n_x1, n_x2, n_mul_ops, n_acc, n_rsp, n_rt_cyc;
   int                 exp_ptr, inf_idx;
   bit                 inflight, byp, acc_chk, res_chk;
   int                 grants[$];

   task automatic drive();
      logic [NUM_REQ*WIDTH-1:0] ta, tb;
      logic [NUM_REQ-1:0]       rv;
      logic [31:0]              h;
      ta = '0;
      tb = '0;
      rv = '0;
      gate = rand_gate ? NUM_REQ'($urandom) : '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rq[i].size() > 0) begin
            h  = rq[i][0];
            ta = ta | ((NUM_REQ*WIDTH)'(h[31:16]) << (i*WIDTH));
            tb = tb | ((NUM_REQ*WIDTH)'(h[15:0]) << (i*WIDTH));
            if (1'(gate >> i)) rv = rv | oh(i);
         end
      end
      req_tvalid   = rv;
      req_tdata_a  = ta;
      req_tdata_b  = tb;
      rsp_tready   = rand_rsp ? NUM_REQ'($urandom) : rsp_rdy;
      mul_tready_1 = 1'b1;
      mul_tready_2 = stall_after_1 ? (m_have_a && stall_cnt == 0) : 1'b1;
      mul_tvalid_r = m_res_vld;
      mul_tdata_r  = m_res;
   endtask

   task automatic clr_counts();
      n_x1 = 0; n_x2 = 0; n_mul_ops = 0; n_rt_cyc = 0;
      grants.delete();
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
      inflight = 0; byp = 0; acc_chk = 0; res_chk = 0;
      m_have_a = 0; m_have_b = 0; m_res_vld = 0; m_cnt = 0; stall_cnt = 0;
      m_a = '0; m_b = '0; m_res = '0; inf_p = '0;
      exp_ptr = 0;
      clr_counts();
   endtask

   task automatic push(input int r, input logic [15:0] a, input logic [15:0] b);
      rq[r].push_back({a, b});
   endtask

   task automatic check_rst(input string tag);
      check_eq({tag, "_ctl"}, 32'({req_tready, rsp_tvalid, mul_tvalid_1, mul_tvalid_2, mul_tready_r}), 32'd0);
      check_eq({tag, "_rsp"}, 32'(rsp_tdata), 32'd0);
      check_eq({tag, "_m1"},  32'(mul_tdata_1), 32'd0);
      check_eq({tag, "_m2"},  32'(mul_tdata_2), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 check_rst(tag);
      clear_model();
      drive();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic wait_rsp(input int target, input int budget, input string tag);
      int c;
      c = 0;
      while (n_rsp < target && c < budget) begin
         @(posedge clk);
         c++;
      end
      check_eq({tag, "_done"}, n_rsp, target);
      repeat (2) @(posedge clk);
   endtask

   task automatic chk_mul(input string tag);
      check_eq({tag, "_x1"}, n_x1, n_mul_ops);
      check_eq({tag, "_x2"}, n_x2, n_mul_ops);
   endtask

   // Reference model: samples mid-cycle, drives 1 time unit after each rising edge
   initial begin : env
      logic [NUM_REQ-1:0] vld, rt, exp_oh;
      logic [31:0]        h;
      logic [15:0]        a, b;
      int                 w, k;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            vld = req_tvalid;
            rt  = req_tready;
            if (acc_chk) begin
               acc_chk = 0;
               if (byp) begin
                  check_eq("byp_rsp", 32'(rsp_tvalid), 32'(oh(inf_idx)));
                  check_eq("byp_nomul", 32'({mul_tvalid_1, mul_tvalid_2}), 32'd0);
               end else begin
                  check_eq("issue_lat", 32'({mul_tvalid_1, mul_tvalid_2}), 32'd3);
               end
            end
            if (res_chk) begin
               res_chk = 0;
               check_eq("rsp_lat", 32'(rsp_tvalid), 32'(oh(inf_idx)));
            end
            w = -1;
            if (!inflight) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  k = (exp_ptr + i) % NUM_REQ;
                  if (w < 0 && 1'(vld >> k)) w = k;
               end
            end
            exp_oh = (w >= 0) ? oh(w) : '0;
            check_eq("grant", 32'(rt), 32'(exp_oh));
            if (rt != '0) n_rt_cyc++;
            if (w >= 0 && 1'(rt >> w)) begin
               h = rq[w].pop_front();
               a = h[31:16];
               b = h[15:0];
               inflight = 1;
               inf_idx  = w;
               exp_ptr  = (w + 1) % NUM_REQ;
               grants.push_back(w);
               n_acc++;
               acc_chk = 1;
               byp   = BYP && (a == 16'd0 || b == 16'd0);
               inf_p = prod16(a, b);
               if (!byp) n_mul_ops++;
            end
            if (mul_tvalid_1 && mul_tready_1) begin
               n_x1++;
               m_a = mul_tdata_1;
               m_have_a = 1;
               if (stall_after_1) stall_cnt = 5;
            end
            if (mul_tvalid_2 && mul_tready_2) begin
               n_x2++;
               m_b = mul_tdata_2;
               m_have_b = 1;
            end
            if (m_res_vld && mul_tready_r) begin
               m_res_vld = 0;
               m_have_a  = 0;
               m_have_b  = 0;
               res_chk   = 1;
            end
            if (rsp_tvalid != '0) begin
               check_eq("rsp_vld", 32'(rsp_tvalid), inflight ? 32'(oh(inf_idx)) : 32'd0);
               check_eq("rsp_data", 32'(rsp_tdata), 32'(inf_p));
               if (inflight && 1'(rsp_tvalid >> inf_idx) && 1'(rsp_tready >> inf_idx)) begin
                  inflight = 0;
                  last_rsp = rsp_tdata;
                  n_rsp++;
               end
            end
         end
         @(posedge clk);
         #1;
         if (m_have_a && m_have_b && !m_res_vld) begin
            m_cnt++;
            if (m_cnt >= mul_lat) begin
               m_res_vld = 1;
               m_res     = prod16(m_a, m_b);
               m_cnt     = 0;
            end
         end
         if (stall_cnt > 0) stall_cnt--;
         drive();
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : tests
      int c, base, acc0;
      logic [15:0] a, b;
      reset_n = 1'b0;
      rand_gate = 0; rand_rsp = 0; stall_after_1 = 0;
      rsp_rdy = '1; mul_lat = 17;
      n_acc = 0; n_rsp = 0; last_rsp = '0;
      clear_model();
      drive();
      repeat (3) @(posedge clk);
      #2 check_rst("por");
      reset_n = 1'b1;

      // 1: single op through a 17-cycle multiplier
      push(0, 16'd3, -16'sd5);
      wait_rsp(1, 200, "t1");
      check_eq("t1_prod", 32'(last_rsp), 32'hFFF1);
      check_eq("t1_rdy_cyc", n_rt_cyc, 1);
      check_eq("t1_gnt", grants.size() > 0 ? grants[0] : -1, 0);
      chk_mul("t1");

      // 2: all requesters busy, strict rotation from pointer 0
      do_reset("t2rst");
      mul_lat = 3;
      for (int r = 0; r < NUM_REQ; r++)
         for (int j = 0; j < 2; j++)
            push(r, 16'($urandom_range(1, 1000)), 16'($urandom_range(1, 1000)));
      base = n_rsp;
      wait_rsp(base + 8, 400, "t2");
      check_eq("t2_ngnt", grants.size(), 8);
      for (int j = 0; j < grants.size(); j++) check_eq("t2_order", grants[j], j % NUM_REQ);
      chk_mul("t2");

      // 3: operand B port stalled after A transfers
      clr_counts();
      stall_after_1 = 1;
      push(2, 16'd7, 16'd9);
      wait_rsp(n_rsp + 1, 200, "t3");
      check_eq("t3_prod", 32'(last_rsp), 32'd63);
      chk_mul("t3");
      stall_after_1 = 0;

      // 4: response back-pressure holds everything else off
      clr_counts();
      rsp_rdy[2] = 1'b0;
      push(2, 16'd100, -16'sd3);
      c = 0;
      while (!rsp_tvalid[2] && c < 200) begin
         @(posedge clk);
         c++;
      end
      check_eq("t4_rspv", 32'(rsp_tvalid), 32'(oh(2)));
      push(0, 16'd5, 16'd5);
      acc0 = n_acc;
      repeat (10) @(posedge clk);
      check_eq("t4_noacc", n_acc, acc0);
      check_eq("t4_hold", 32'(rsp_tdata), 32'(prod16(16'd100, -16'sd3)));
      rsp_rdy[2] = 1'b1;
      wait_rsp(n_rsp + 2, 200, "t4");
      check_eq("t4_prod0", 32'(last_rsp), 32'd25);

      // 5: reset while waiting for the multiplier
      mul_lat = 17;
      push(3, 16'd11, 16'd13);
      c = 0;
      while (!(m_have_a && m_have_b) && c < 100) begin
         @(posedge clk);
         c++;
      end
      check_eq("t5_inwait", 32'(m_have_a && m_have_b), 32'd1);
      repeat (3) @(posedge clk);
      do_reset("t5rst");
      push(3, 16'd2, 16'd3);
      push(1, 16'd4, 16'd5);
      wait_rsp(n_rsp + 2, 200, "t5");
      check_eq("t5_first", grants.size() > 0 ? grants[0] : -1, 1);
      check_eq("t5_second", grants.size() > 1 ? grants[1] : -1, 3);

      // 6: zero operand
      clr_counts();
      push(1, 16'd0, 16'd123);
      wait_rsp(n_rsp + 1, 200, "t6");
      check_eq("t6_prod", 32'(last_rsp), 32'd0);
      check_eq("t6_mulops", n_x1, BYP ? 0 : 1);
      chk_mul("t6");

      // 7: randomized traffic, gating and back-pressure
      clr_counts();
      rand_gate = 1;
      rand_rsp  = 1;
      mul_lat   = int'($urandom_range(1, 5));
      stall_after_1 = 1'($urandom);
      for (int j = 0; j < 60; j++) begin
         a = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
         b = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
         push(int'($urandom_range(NUM_REQ - 1)), a, b);
      end
      wait_rsp(n_rsp + 60, 20000, "t7");
      chk_mul("t7");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
